// File: rtl/count_seq_checker.sv
// Sequence checker for free-running up counters: verifies +1 steps on each en sample, reports lock/error/restart/wrap.
// Build option CNT_CHECK_STALL_OK_EN: when defined, a repeated value while locked is tolerated as a stall.
module count_seq_checker #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8,
  parameter int LOCK_LEN  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     q_in,
  input  logic                 clear,
  output logic                 locked,
  output logic [WIDTH-1:0]     expected,
  output logic                 err_pulse,
  output logic                 restart_pulse,
  output logic                 wrap_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ERR_CNT_W-1:0] wrap_count
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]     VAL_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]     VAL_MAX  = {WIDTH{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE  = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};
  localparam logic [3:0]           LOCK_TGT = 4'(LOCK_LEN);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     last_q, last_d;
  logic [WIDTH-1:0]     exp_q, exp_d;
  logic [3:0]           match_q, match_d;
  logic                 locked_q, locked_d;
  logic                 err_p_q, err_p_d;
  logic                 rst_p_q, rst_p_d;
  logic                 wrap_p_q, wrap_p_d;
  logic [ERR_CNT_W-1:0] errc_q, errc_d;
  logic [ERR_CNT_W-1:0] wrapc_q, wrapc_d;
  logic [WIDTH-1:0]     next_val;
  logic [3:0]           match_inc;

  assign next_val = last_q + VAL_ONE;

  // Next-state and output computation; clear takes priority over en
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    exp_d     = exp_q;
    match_d   = match_q;
    locked_d  = locked_q;
    err_p_d   = 1'b0;
    rst_p_d   = 1'b0;
    wrap_p_d  = 1'b0;
    errc_d    = errc_q;
    wrapc_d   = wrapc_q;
    match_inc = match_q + 4'd1;
    if (clear) begin
      state_d  = ST_UNLOCKED;
      last_d   = '0;
      exp_d    = '0;
      match_d  = 4'd0;
      locked_d = 1'b0;
      errc_d   = '0;
      wrapc_d  = '0;
    end else if (en) begin
      case (state_q)
        ST_UNLOCKED: begin
          last_d  = q_in;
          exp_d   = q_in + VAL_ONE;
          match_d = 4'd0;
          state_d = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          last_d = q_in;
          exp_d  = q_in + VAL_ONE;
          if (q_in == next_val) begin
            match_d = match_inc;
            if (match_inc >= LOCK_TGT) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end else begin
              state_d = ST_ACQUIRE;
            end
          end else begin
            match_d = 4'd0;
          end
        end
        ST_LOCKED: begin
          // A failed +1 match with q_in==0 implies expected!=0, so this is a restart
          if (q_in == next_val) begin
            last_d = q_in;
            exp_d  = q_in + VAL_ONE;
            if (last_q == VAL_MAX) begin
              wrap_p_d = 1'b1;
              wrapc_d  = sat_inc(wrapc_q);
            end else begin
              wrap_p_d = 1'b0;
            end
          end else if (q_in == '0) begin
            rst_p_d  = 1'b1;
            last_d   = '0;
            exp_d    = VAL_ONE;
            match_d  = 4'd0;
            state_d  = ST_ACQUIRE;
            locked_d = 1'b0;
`ifdef CNT_CHECK_STALL_OK_EN
          end else if (q_in == last_q) begin
            state_d = ST_LOCKED;
`endif
          end else begin
            err_p_d  = 1'b1;
            errc_d   = sat_inc(errc_q);
            last_d   = q_in;
            exp_d    = q_in + VAL_ONE;
            match_d  = 4'd0;
            state_d  = ST_ACQUIRE;
            locked_d = 1'b0;
          end
        end
        default: begin
          state_d  = ST_UNLOCKED;
          locked_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_UNLOCKED;
      last_q   <= '0;
      exp_q    <= '0;
      match_q  <= 4'd0;
      locked_q <= 1'b0;
      err_p_q  <= 1'b0;
      rst_p_q  <= 1'b0;
      wrap_p_q <= 1'b0;
      errc_q   <= '0;
      wrapc_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      exp_q    <= exp_d;
      match_q  <= match_d;
      locked_q <= locked_d;
      err_p_q  <= err_p_d;
      rst_p_q  <= rst_p_d;
      wrap_p_q <= wrap_p_d;
      errc_q   <= errc_d;
      wrapc_q  <= wrapc_d;
    end
  end

  assign locked        = locked_q;
  assign expected      = exp_q;
  assign err_pulse     = err_p_q;
  assign restart_pulse = rst_p_q;
  assign wrap_pulse    = wrap_p_q;
  assign err_count     = errc_q;
  assign wrap_count    = wrapc_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker: driver queues hand-computed expectations, monitor pops and compares.
module tb_count_seq_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] q_in;
  logic       clear;
  logic       locked;
  logic [3:0] expected;
  logic       err_pulse;
  logic       restart_pulse;
  logic       wrap_pulse;
  logic [7:0] err_count;
  logic [7:0] wrap_count;

  typedef struct {
    int         id;
    logic       lk;
    logic [3:0] ex;
    logic       ep;
    logic       rp;
    logic       wp;
    logic [7:0] ec;
    logic [7:0] wc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_step = 0;

  count_seq_checker #(.WIDTH(4), .ERR_CNT_W(8), .LOCK_LEN(2)) dut (
    .clk(clk), .rst(rst), .en(en), .q_in(q_in), .clear(clear),
    .locked(locked), .expected(expected), .err_pulse(err_pulse),
    .restart_pulse(restart_pulse), .wrap_pulse(wrap_pulse),
    .err_count(err_count), .wrap_count(wrap_count)
  );

  always #5 clk = ~clk;

  // Monitor: one registered response per driven cycle, sampled 1 ns after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (locked !== e.lk || expected !== e.ex || err_pulse !== e.ep ||
            restart_pulse !== e.rp || wrap_pulse !== e.wp ||
            err_count !== e.ec || wrap_count !== e.wc) begin
          n_bad++;
          $display("FAIL step%0d: got lk=%b ex=%0d ep=%b rp=%b wp=%b ec=%0d wc=%0d, want lk=%b ex=%0d ep=%b rp=%b wp=%b ec=%0d wc=%0d",
                   e.id, locked, expected, err_pulse, restart_pulse, wrap_pulse, err_count, wrap_count,
                   e.lk, e.ex, e.ep, e.rp, e.wp, e.ec, e.wc);
        end
      end
    end
  end

  task automatic step(input logic e_i, input logic [3:0] q, input logic c,
                      input logic lk, input logic [3:0] ex, input logic ep,
                      input logic rp, input logic wp, input logic [7:0] ec,
                      input logic [7:0] wc);
    exp_t x;
    @(posedge clk);
    #2;
    en    = e_i;
    q_in  = q;
    clear = c;
    x.id = n_step; x.lk = lk; x.ex = ex; x.ep = ep; x.rp = rp; x.wp = wp; x.ec = ec; x.wc = wc;
    sb.push_back(x);
    n_step++;
  endtask

  initial begin
    logic [3:0] l_v;
    logic [3:0] bad_v;
    logic [7:0] ec_v;
    int         wait_cnt;
    rst = 1'b1; en = 1'b0; q_in = 4'd0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Acquire and lock on 0,1,2
    step(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b1, 4'd0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b1, 4'd1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b1, 4'd2, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b0, 4'd9, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    for (int v = 3; v <= 14; v++)
      step(1'b1, 4'(v), 1'b0, 1'b1, 4'(v + 1), 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    // Wrap 15 -> 0
    step(1'b1, 4'd15, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b1, 4'd0,  1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1);
    for (int v = 1; v <= 5; v++)
      step(1'b1, 4'(v), 1'b0, 1'b1, 4'(v + 1), 1'b0, 1'b0, 1'b0, 8'd0, 8'd1);
    // Sequence error at last=5, then relock on 10,11
    step(1'b1, 4'd9,  1'b0, 1'b0, 4'd10, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1);
    step(1'b1, 4'd10, 1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
    step(1'b1, 4'd11, 1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
    // Synchronous clear overrides en
    step(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b1, 4'd5, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b1, 4'd6, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b1, 4'd7, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    // Counter restart at last=7
    step(1'b1, 4'd0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    step(1'b1, 4'd1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b1, 4'd2, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b1, 4'd3, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b1, 4'd4, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    // Stall at last=4
`ifdef CNT_CHECK_STALL_OK_EN
    step(1'b1, 4'd4, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b0, 4'd4, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
`else
    step(1'b1, 4'd4, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
    step(1'b0, 4'd4, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0);
`endif

    // Asynchronous reset between edges
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (locked !== 1'b0 || expected !== 4'd0 || err_pulse !== 1'b0 || restart_pulse !== 1'b0 ||
        wrap_pulse !== 1'b0 || err_count !== 8'd0 || wrap_count !== 8'd0) begin
      n_bad++;
      $display("FAIL async_rst: got lk=%b ex=%0d ec=%0d wc=%0d, want all zero",
               locked, expected, err_count, wrap_count);
    end
    @(negedge clk);
    rst = 1'b0;

    // Saturation: repeatedly lock then inject an error
    step(1'b1, 4'd0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    l_v  = 4'd0;
    ec_v = 8'd0;
    for (int i = 0; i < 260; i++) begin
      step(1'b1, l_v + 4'd1, 1'b0, 1'b0, l_v + 4'd2, 1'b0, 1'b0, 1'b0, ec_v, 8'd0);
      step(1'b1, l_v + 4'd2, 1'b0, 1'b1, l_v + 4'd3, 1'b0, 1'b0, 1'b0, ec_v, 8'd0);
      bad_v = l_v + 4'd8;
      if (bad_v == 4'd0) bad_v = 4'd1;
      if (ec_v != 8'd255) ec_v = ec_v + 8'd1;
      step(1'b1, bad_v, 1'b0, 1'b0, bad_v + 4'd1, 1'b1, 1'b0, 1'b0, ec_v, 8'd0);
      l_v = bad_v;
    end
    step(1'b0, 4'd0, 1'b0, 1'b0, bad_v + 4'd1, 1'b0, 1'b0, 1'b0, 8'd255, 8'd0);

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #3;
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Reader-side companion to the team's free-running up counters. Samples a counter output bus on a qualifier strobe and checks that it advances by exactly +1 mod 2^WIDTH per sample.
- Reports lock status, sequence errors, counter restarts and wrap-arounds.
- Sits beside any counter instance, in benches or on-chip, as a health monitor.
- Its inputs are treated as already synchronous to clk.

Parameters:
WIDTH, 4, width of observed counter value
ERR_CNT_W, 8, width of saturating error and wrap counters
LOCK_LEN, 2, consecutive correct +1 steps needed to declare lock (1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  sample strobe; q_in is evaluated only in cycles where en=1
q_in  input  WIDTH  observed counter value
clear  input  1  synchronous clear of FSM and statistics
locked  output  1  sequence tracking established
expected  output  WIDTH  next value the checker expects (last+1 mod 2^WIDTH)
err_pulse  output  1  one-cycle pulse on sequence error while locked
restart_pulse  output  1  one-cycle pulse when q_in=0 arrives unexpectedly while locked
wrap_pulse  output  1  one-cycle pulse on legal max->0 transition while locked
err_count  output  ERR_CNT_W  saturating count of err_pulse events
wrap_count  output  ERR_CNT_W  saturating count of wrap_pulse events

Behaviour:
- Reset (rst=1, async): FSM=UNLOCKED, last=0, match_cnt=0, all outputs 0, counts 0.
- All outputs are registered. The response appears the cycle after the en sample edge. Pulses last exactly one clk.
- With en=0: no state change, pulses deassert, counts hold.
- clear=1 at a rising edge overrides en. Effect is identical to reset, applied synchronously.
- FSM states:
  - UNLOCKED: on en, last<=q_in, match_cnt<=0, go ACQUIRE.
  - ACQUIRE: on en:
    - if q_in==last+1, match_cnt++; otherwise match_cnt<=0.
    - last<=q_in in both cases.
    - When the incremented match_cnt reaches LOCK_LEN, go LOCKED and set locked=1 on the same edge.
  - LOCKED: on en:
    - q_in==expected: last<=q_in. If last was all-ones, wrap_pulse=1 and wrap_count++.
    - q_in==0 and expected!=0: restart_pulse=1, last<=0, match_cnt<=0, go ACQUIRE, locked<=0. err_count unchanged.
    - q_in==last (stall): handled per the optional feature.
    - Any other value: err_pulse=1, err_count++, last<=q_in, match_cnt<=0, go ACQUIRE, locked<=0.
- No pulses are generated in UNLOCKED or ACQUIRE.
- expected = last+1, truncated to WIDTH (all-ones+1 = 0). It is valid in all states.
- Counters saturate at 2^ERR_CNT_W-1 and never wrap.
- rst asserted mid-operation clears everything immediately, independent of clk.

Optional Feature:
Macro CNT_CHECK_STALL_OK_EN.
- Defined: in LOCKED, q_in==last is a tolerated stall. No pulse, state and last unchanged, lock kept.
- Undefined: a stall is treated as a sequence error (err_pulse, err_count++, go ACQUIRE). Exception: q_in==0 with last==0 takes the restart path.

Test Plan:
- Reset then en=1 each cycle with q_in 0,1,2 and LOCK_LEN=2 -> locked=1 one cycle after the q_in=2 sample; expected=3; err_count=0.
- Locked, feed 13,14,15,0,1 -> single wrap_pulse after the 0 sample; wrap_count=1; no err_pulse.
- Locked at last=5, feed q_in=9 -> err_pulse one cycle, err_count=1, locked=0. Then 10,11 -> locked=1 again.
- Locked at last=7, feed q_in=0 (counter reset) -> restart_pulse=1, err_count unchanged, locked=0, expected=1.
- Locked at last=4, feed q_in=4 -> with CNT_CHECK_STALL_OK_EN: no pulse, locked stays 1. Without it: err_pulse, err_count+1.
- Mid-stream, assert clear, and separately assert rst asynchronously between edges -> all outputs 0. For rst, outputs clear before the next clk edge. 256+ injected errors with ERR_CNT_W=8 -> err_count holds at 255.
